// File: rtl/memory_access_pkg.sv
// memory_access_pkg: widths, memory opcodes, FSM states and decode helpers
// shared by the memory-access stage and its load-extension datapath.
`default_nettype none

package memory_access_pkg;

  localparam int XLEN          = 64;
  localparam int MEMOP_LEN     = 4;
  localparam int REG_ADDRWIDTH = 5;

  localparam logic [MEMOP_LEN-1:0] MEMOP_NONE = 4'd0;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LB   = 4'd1;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LBU  = 4'd2;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LH   = 4'd3;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LHU  = 4'd4;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LW   = 4'd5;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LWU  = 4'd6;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LD   = 4'd7;
  localparam logic [MEMOP_LEN-1:0] MEMOP_SB   = 4'd8;
  localparam logic [MEMOP_LEN-1:0] MEMOP_SH   = 4'd9;
  localparam logic [MEMOP_LEN-1:0] MEMOP_SW   = 4'd10;
  localparam logic [MEMOP_LEN-1:0] MEMOP_SD   = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_load(input logic [MEMOP_LEN-1:0] op);
    return (op >= MEMOP_LB) && (op <= MEMOP_LD);
  endfunction

  function automatic logic is_store(input logic [MEMOP_LEN-1:0] op);
    return (op >= MEMOP_SB) && (op <= MEMOP_SD);
  endfunction

  // Codes 12..15 fall into the default arm and behave as no-strobe, never-misaligned.
  function automatic logic [7:0] base_strb(input logic [MEMOP_LEN-1:0] op);
    case (op)
      MEMOP_SB: return 8'h01;
      MEMOP_SH: return 8'h03;
      MEMOP_SW: return 8'h0F;
      MEMOP_SD: return 8'hFF;
      default:  return 8'h00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [MEMOP_LEN-1:0] op,
                                         input logic [2:0] a);
    case (op)
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: return a[0];
      MEMOP_LW, MEMOP_LWU, MEMOP_SW: return |a[1:0];
      MEMOP_LD, MEMOP_SD:            return |a;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// load_extend: steers the addressed bytes of a raw 8-byte read down to bit 0
// and sign- or zero-extends them according to the load opcode.
`default_nettype none

module load_extend
  import memory_access_pkg::*;
(
  input  logic [XLEN-1:0]      rsp_data_i,
  input  logic [2:0]           addr_i,
  input  logic [MEMOP_LEN-1:0] mem_op_i,
  output logic [XLEN-1:0]      ld_data_o
);

  logic [XLEN-1:0] sh;

  always_comb begin
    sh = rsp_data_i >> {addr_i, 3'b000};
    case (mem_op_i)
      MEMOP_LB:  ld_data_o = {{56{sh[7]}}, sh[7:0]};
      MEMOP_LBU: ld_data_o = {56'd0, sh[7:0]};
      MEMOP_LH:  ld_data_o = {{48{sh[15]}}, sh[15:0]};
      MEMOP_LHU: ld_data_o = {48'd0, sh[15:0]};
      MEMOP_LW:  ld_data_o = {{32{sh[31]}}, sh[31:0]};
      MEMOP_LWU: ld_data_o = {32'd0, sh[31:0]};
      default:   ld_data_o = sh;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/memory_access.sv
// memory_access: MEM stage; takes the execute bundle, issues at most one
// aligned bus request with lane steering, and hands the write-back value on.
`default_nettype none

module memory_access
  import memory_access_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          alu_out,
  input  logic [XLEN-1:0]          rs2_data,
  input  logic [MEMOP_LEN-1:0]     mem_op,
  input  logic [REG_ADDRWIDTH-1:0] rd_idx,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [XLEN-1:0]          mem_req_addr,
  output logic                     mem_req_wen,
  output logic [XLEN-1:0]          mem_req_wdata,
  output logic [7:0]               mem_req_wstrb,
  input  logic                     mem_rsp_valid,
  input  logic [XLEN-1:0]          mem_rsp_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REG_ADDRWIDTH-1:0] out_rd_idx,
  output logic [XLEN-1:0]          out_wb_data,
  output logic                     out_misaligned
);

  state_e                     state_q;
  logic [2:0]                 addr_lo_q;
  logic [MEMOP_LEN-1:0]       op_q;
  logic                       req_valid_q;
  logic [XLEN-1:0]            req_addr_q;
  logic                       req_wen_q;
  logic [XLEN-1:0]            req_wdata_q;
  logic [7:0]                 req_wstrb_q;
  logic                       out_valid_q;
  logic [REG_ADDRWIDTH-1:0]   out_rd_q;
  logic [XLEN-1:0]            out_wb_q;
  logic                       out_mis_q;

  logic [XLEN-1:0]            ld_value;
  logic [XLEN-1:0]            st_wdata_d;
  logic [7:0]                 st_wstrb_d;
  logic                       st_d;

  assign st_d       = is_store(mem_op);
  assign st_wdata_d = st_d ? (rs2_data << {alu_out[2:0], 3'b000}) : '0;
  assign st_wstrb_d = base_strb(mem_op) << alu_out[2:0];

  load_extend u_load_extend (
    .rsp_data_i (mem_rsp_data),
    .addr_i     (addr_lo_q),
    .mem_op_i   (op_q),
    .ld_data_o  (ld_value)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_lo_q   <= '0;
      op_q        <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_wen_q   <= 1'b0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_wb_q    <= '0;
      out_mis_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            addr_lo_q <= alu_out[2:0];
            op_q      <= mem_op;
            out_rd_q  <= rd_idx;
            if (!is_load(mem_op) && !st_d) begin
              out_wb_q    <= alu_out;
              out_mis_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else if (is_misaligned(mem_op, alu_out[2:0])) begin
              out_wb_q    <= '0;
              out_mis_q   <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              req_valid_q <= 1'b1;
              req_addr_q  <= {alu_out[XLEN-1:3], 3'b000};
              req_wen_q   <= st_d;
              req_wdata_q <= st_wdata_d;
              req_wstrb_q <= st_wstrb_d;
              state_q     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          // A store's response is only the write acknowledge; it carries no data.
          if (mem_rsp_valid) begin
            out_wb_q    <= is_load(op_q) ? ld_value : '0;
            out_mis_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready       = (state_q == ST_IDLE);
  assign mem_req_valid  = req_valid_q;
  assign mem_req_addr   = req_addr_q;
  assign mem_req_wen    = req_wen_q;
  assign mem_req_wdata  = req_wdata_q;
  assign mem_req_wstrb  = req_wstrb_q;
  assign out_valid      = out_valid_q;
  assign out_rd_idx     = out_rd_q;
  assign out_wb_data    = out_wb_q;
  assign out_misaligned = out_mis_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
// tb_memory_access: directed and randomized transactions against a
// behavioural model of the memory-access stage.
`default_nettype none

module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_out;
  logic [63:0] rs2_data;
  logic [3:0]  mem_op;
  logic [4:0]  rd_idx;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd_idx;
  logic [63:0] out_wb_data;
  logic        out_misaligned;

  int checks   = 0;
  int failures = 0;
  int nreq     = 0;

  memory_access dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_out        (alu_out),
    .rs2_data       (rs2_data),
    .mem_op         (mem_op),
    .rd_idx         (rd_idx),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wstrb  (mem_req_wstrb),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rd_idx     (out_rd_idx),
    .out_wb_data    (out_wb_data),
    .out_misaligned (out_misaligned)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_req_valid && mem_req_ready) nreq <= nreq + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access size in bytes, 0 for non-memory codes.
  function automatic int op_size(input int op);
    case (op)
      1, 2, 8:  return 1;
      3, 4, 9:  return 2;
      5, 6, 10: return 4;
      7, 11:    return 8;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [63:0] model_load(input int op, input logic [63:0] addr,
                                             input logic [63:0] rsp);
    int          sz  = op_size(op);
    int          ofs = int'(addr % 8);
    logic [63:0] v   = rsp >> (8 * ofs);
    logic [63:0] m;
    if (sz < 8) begin
      m = (64'd1 << (8 * sz)) - 64'd1;
      v = v & m;
      if ((op == 1 || op == 3 || op == 5) && v[8*sz-1]) v = v | ~m;
    end
    return v;
  endfunction

  task automatic txn(input int op, input logic [63:0] addr, input logic [63:0] rs2,
                     input logic [4:0] rd, input logic [63:0] rsp,
                     input int req_stall, input int rsp_stall, input int out_stall);
    int          sz     = op_size(op);
    bit          ld     = (op >= 1 && op <= 7);
    bit          st     = (op >= 8 && op <= 11);
    bit          mis    = (sz != 0) && ((addr % sz) != 0);
    int          n0     = nreq;
    logic [63:0] exp_wb;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
    exp_strb  = 8'(((16'd1 << sz) - 16'd1) << (addr % 8));
    exp_wdata = rs2 << (8 * (addr % 8));
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; mem_op = 4'(op); alu_out = addr; rs2_data = rs2; rd_idx = rd;
    tick();
    in_valid = 0; alu_out = $urandom; rs2_data = $urandom; mem_op = 4'($urandom);
    chk("in_ready_busy", in_ready, 0);
    if (sz == 0 || mis) begin
      exp_wb = (sz == 0) ? addr : 64'd0;
      chk("direct_req_valid", mem_req_valid, 0);
    end else begin
      for (int i = 0; i <= req_stall; i++) begin
        chk("req_valid", mem_req_valid, 1);
        chk("req_addr", mem_req_addr, addr & ~64'd7);
        chk("req_wen", mem_req_wen, st);
        if (st) begin
          chk("req_wstrb", mem_req_wstrb, exp_strb);
          chk("req_wdata", mem_req_wdata, exp_wdata);
        end
        chk("out_valid_req", out_valid, 0);
        if (i == req_stall) mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
      end
      for (int i = 0; i < rsp_stall; i++) begin
        mem_rsp_valid = 0; mem_rsp_data = {$urandom, $urandom};
        tick();
        chk("out_valid_resp", out_valid, 0);
      end
      mem_rsp_valid = 1; mem_rsp_data = rsp;
      tick();
      mem_rsp_valid = 0; mem_rsp_data = {$urandom, $urandom};
      exp_wb = ld ? model_load(op, addr, rsp) : 64'd0;
    end
    for (int i = 0; i <= out_stall; i++) begin
      chk("out_valid", out_valid, 1);
      chk("out_wb", out_wb_data, exp_wb);
      chk("out_mis", out_misaligned, mis);
      chk("out_rd", out_rd_idx, rd);
      if (i == out_stall) out_ready = 1;
      tick();
      out_ready = 0;
    end
    chk("out_valid_drop", out_valid, 0);
    chk("bus_txn_count", nreq - n0, (sz != 0 && !mis) ? 1 : 0);
  endtask

  initial begin
    rst = 1; in_valid = 0; alu_out = 0; rs2_data = 0; mem_op = 0; rd_idx = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0; out_ready = 0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mis", out_misaligned, 0);
    chk("rst_wen", mem_req_wen, 0);
    chk("rst_addr", mem_req_addr, 0);
    chk("rst_wdata", mem_req_wdata, 0);
    chk("rst_wstrb", mem_req_wstrb, 0);
    chk("rst_wb", out_wb_data, 0);
    chk("rst_rd", out_rd_idx, 0);
    rst = 0;
    tick();

    txn(0, 64'h1234, 64'h0, 5'd3, 64'h0, 0, 0, 0);
    txn(1, 64'h80000003, 64'h0, 5'd4, 64'h0000_0000_8000_0000, 0, 0, 0);
    txn(2, 64'h80000003, 64'h0, 5'd5, 64'h0000_0000_8000_0000, 0, 0, 0);
    txn(9, 64'h80000006, 64'hABCD, 5'd6, 64'h0, 0, 0, 0);
    txn(5, 64'h80000002, 64'h0, 5'd7, 64'h0, 0, 0, 0);
    txn(7, 64'h80000010, 64'h0, 5'd8, 64'hDEAD_BEEF_0123_4567, 3, 1, 2);
    txn(14, 64'hFFFF_0000_1111_2223, 64'h0, 5'd9, 64'h0, 0, 0, 1);

    // Reset asserted mid-cycle while waiting for a response.
    in_valid = 1; mem_op = 4'd5; alu_out = 64'h80000004; rd_idx = 5'd10;
    tick();
    in_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    #2 rst = 1;
    #1;
    chk("rst_resp_in_ready", in_ready, 1);
    chk("rst_resp_req_valid", mem_req_valid, 0);
    chk("rst_resp_out_valid", out_valid, 0);
    chk("rst_resp_addr", mem_req_addr, 0);
    chk("rst_resp_rd", out_rd_idx, 0);
    #1 rst = 0;
    tick();
    mem_rsp_valid = 1; mem_rsp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem_rsp_valid = 0;
    chk("stale_rsp_out_valid", out_valid, 0);
    chk("stale_rsp_in_ready", in_ready, 1);

    for (int k = 0; k < 150; k++) begin
      txn(int'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
          5'($urandom), {$urandom, $urandom},
          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_access.md
# memory_access

Memory-access stage of the NPC core, sitting directly after `execute`. It accepts the execute result bundle (ALU result as effective address, store data, memory opcode, rd index) through a valid/ready handshake. It performs at most one 8-byte-aligned request on a simple request/response data bus, including byte-lane steering and load sign or zero extension. It then presents the write-back value to the next stage through a second valid/ready handshake.

## Interface
- Parameters: none. `XLEN` = 64, `MEMOP_LEN` = 4 and `REG_ADDRWIDTH` come from `sysconfig.v`.
- Reset: one clock; reset is asynchronous and active-high. Ports are `clk` and `rst`.
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous reset, active-high.
- `in_valid`  in  1  execute bundle valid.
- `in_ready`  out  1  stage can accept a bundle.
- `alu_out`  in  XLEN  ALU result; the effective address for loads and stores.
- `rs2_data`  in  XLEN  store data.
- `mem_op`  in  MEMOP_LEN  memory opcode.
- `rd_idx`  in  REG_ADDRWIDTH  destination register.
- `mem_req_valid`  out  1  bus request valid.
- `mem_req_ready`  in  1  bus accepts the request.
- `mem_req_addr`  out  XLEN  byte address aligned to 8 (`{addr[63:3],3'b0}`).
- `mem_req_wen`  out  1  1 = store.
- `mem_req_wdata`  out  XLEN  store data shifted to its byte lanes.
- `mem_req_wstrb`  out  8  byte enables.
- `mem_rsp_valid`  in  1  response valid; for loads it carries data, for stores it is the write acknowledge.
- `mem_rsp_data`  in  XLEN  raw 8-byte read data.
- `out_valid`  out  1  write-back bundle valid.
- `out_ready`  in  1  write-back stage accepts the bundle.
- `out_rd_idx`  out  REG_ADDRWIDTH  destination register.
- `out_wb_data`  out  XLEN  value to write back.
- `out_misaligned`  out  1  the access was misaligned and no bus request was issued.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- `in_ready` = (state == IDLE).
- **IDLE, on accept:** when `in_valid` is high, latch addr, rs2, op and rd.
  - Non-memory op (`MEMOP_NONE`): go to DONE with `wb` = `alu_out`.
  - Misaligned access: go to DONE with `wb` = 0 and `out_misaligned` = 1. Misaligned means a halfword with addr[0] ≠ 0, a word with addr[1:0] ≠ 0, or a doubleword with addr[2:0] ≠ 0.
  - Otherwise: go to REQ.
- **REQ:**
  - `mem_req_valid` = 1.
  - Address, wdata, wstrb and wen are driven from the latched values and held stable until `mem_req_ready`.
  - On `mem_req_ready`, go to RESP.
- **RESP:**
  - The stage waits for `mem_rsp_valid`.
  - For a load: `sh` = `mem_rsp_data >> (addr[2:0]*8)`. Extract `sh[7:0]`, `sh[15:0]`, `sh[31:0]` or `sh[63:0]`, sign-extend for LB/LH/LW and zero-extend for LBU/LHU/LWU. Then go to DONE.
  - For a store: `wb` = 0, then go to DONE.
- **Store lane steering:**
  - `wstrb` = base mask << addr[2:0]. Base masks: SB 0x01, SH 0x03, SW 0x0F, SD 0xFF.
  - `wdata` = `rs2 << (addr[2:0]*8)`.
- **DONE:**
  - `out_valid` = 1, with outputs held stable.
  - On `out_ready`, go to IDLE.
  - No new input is accepted in the same cycle as the DONE handshake.
- **MEMOP encoding:** 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD, 8 SB, 9 SH, 10 SW, 11 SD. Codes 12–15 are treated as NONE.

## Timing
- Reset values:
  - State is IDLE, so `in_ready` = 1.
  - `mem_req_valid`, `out_valid`, `out_misaligned` and `mem_req_wen` are 0.
  - All data, address and strobe outputs and `out_rd_idx` are 0.
- Latency, with the accept at cycle T:
  - Non-memory op: `out_valid` at T+1.
  - Memory op with zero-wait bus: `mem_req_valid` at T+1; if `mem_req_ready` is high that cycle, RESP at T+2; if `mem_rsp_valid` is also high at T+2, `out_valid` at T+3.
- Bus protocol:
  - `mem_req_valid` never drops before `mem_req_ready`.
  - `mem_rsp_valid` is ignored outside RESP.
  - The bus never returns a response in the same cycle as the request handshake.
- Back-pressure: `out_ready` held low keeps DONE and its outputs stable indefinitely.
- Reset mid-operation: an asynchronous assert in any state returns the stage to IDLE immediately. A response arriving after reset is ignored.

## Structure
- MEMOP codes, `MEMOP_LEN` and the FSM state encodings go in `sysconfig.v`, the shared include.
- One sub-module: `load_extend`, combinational, mapping (`rsp_data`, `addr[2:0]`, `mem_op`) to the extended load value.

## Test plan
- **Non-memory op:** `mem_op` = NONE, `alu_out` = 0x1234 → `out_valid` at T+1, `out_wb_data` = 0x1234, and no `mem_req_valid`.
- **LB sign extension:** LB at addr 0x80000003, `rsp_data` = 0x0000_0000_8000_0000 → `mem_req_addr` = 0x80000000, `out_wb_data` = 0xFFFF_FFFF_FFFF_FF80. Repeating with LBU gives 0x80.
- **SH lane steering:** SH at addr 0x80000006, `rs2` = 0xABCD → `wstrb` = 0xC0, `wdata` = 0xABCD_0000_0000_0000, `wen` = 1. After the ack, `out_wb_data` = 0.
- **Misaligned load:** LW at 0x80000002 → no bus request, `out_valid` at T+1, `out_misaligned` = 1.
- **Stalls:** `mem_req_ready` low for 3 cycles then `out_ready` low for 2 cycles → request and output fields held stable, and exactly one bus transaction.
- **Reset in RESP:** assert `rst` while in RESP → all outputs 0 and `in_ready` = 1 immediately; a stale `mem_rsp_valid` afterwards does not produce `out_valid`.
